mac_result_reader: RTL and testbench

MAC_RESULT_READER -- requirements
Module: mac_result_reader

---
 rtl/mac_pkg.sv | 9 +
 rtl/mac_bit_counter.sv | 18 +
 rtl/mac_result_reader.sv | 52 +++++
 tb/tb_mac_result_reader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants and state encoding for the MAC result readout path.
package mac_pkg;
  localparam int DEFAULT_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FIN   = 2'b10
  } state_t;
endpackage

// File: rtl/mac_bit_counter.sv
// mac_bit_counter: loadable down-counter tracking the bits left to send; zero flags the last bit.
module mac_bit_counter #(
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          R_N,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK or negedge R_N)
    if (!R_N) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mac_result_reader.sv
// mac_result_reader: captures an accumulator word on START and streams it MSB first
// over a valid/ready serial link, holding the accumulator bank while the readout runs.
module mac_result_reader
  import mac_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             R_N,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             SOUT_READY,
  output logic             SOUT,
  output logic             SOUT_VALID,
  output logic             REG_HOLD,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic cnt_zero, load, step;
  assign load = state == IDLE && START;
  assign step = state == SHIFT && SOUT_READY && !cnt_zero;
  mac_bit_counter #(.CW(CW)) u_cnt (
    .CLK     (CLK),
    .R_N     (R_N),
    .load    (load),
    .load_val(LAST),
    .dec     (step),
    .zero    (cnt_zero)
  );
  always_ff @(posedge CLK or negedge R_N)
    if (!R_N) state <= IDLE;
    else state <= state_nx;
  // FIN and the unused encoding both fall back to IDLE
  always_comb
    state_nx = state == IDLE  ? (START ? SHIFT : IDLE) :
               state == SHIFT ? ((SOUT_READY && cnt_zero) ? FIN : SHIFT) : IDLE;
  always_ff @(posedge CLK or negedge R_N)
    if (!R_N) shreg <= '0;
    else if (load) shreg <= DATA_IN;
    else if (step) shreg <= {shreg[WIDTH-2:0], 1'b0};
  always_comb begin
    SOUT       = state == SHIFT && shreg[WIDTH-1];
    SOUT_VALID = state == SHIFT;
    REG_HOLD   = state == SHIFT;
    BUSY       = state == SHIFT || state == FIN;
    DONE       = state == FIN;
  end
endmodule

// File: tb/tb_mac_result_reader.sv
// tb_mac_result_reader: directed scenarios plus random traffic checked against a word/bit-index model.
module tb_mac_result_reader;
  localparam int W = 16;
  logic CLK = 0, R_N = 1, START = 0, SOUT_READY = 1;
  logic [W-1:0] DATA_IN = '0;
  logic SOUT, SOUT_VALID, REG_HOLD, BUSY, DONE;
  int checks = 0, failures = 0;

  mac_result_reader #(.WIDTH(W)) dut (
    .CLK(CLK), .R_N(R_N), .START(START), .DATA_IN(DATA_IN), .SOUT_READY(SOUT_READY),
    .SOUT(SOUT), .SOUT_VALID(SOUT_VALID), .REG_HOLD(REG_HOLD), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a captured word plus the number of bits already accepted
  logic m_act = 0, m_fin = 0;
  int m_sent = 0;
  logic [W-1:0] m_word = '0;
  always @(posedge CLK or negedge R_N)
    if (!R_N) begin
      m_act = 0; m_fin = 0; m_sent = 0;
    end else if (m_fin) m_fin = 0;
    else if (m_act) begin
      if (SOUT_READY) begin
        m_sent++;
        if (m_sent == W) begin m_act = 0; m_fin = 1; end
      end
    end else if (START) begin
      m_act = 1; m_word = DATA_IN; m_sent = 0;
    end

  always @(negedge CLK) begin
    chk("sout",  SOUT,       m_act ? 32'(m_word[W-1-m_sent]) : 0);
    chk("valid", SOUT_VALID, 32'(m_act));
    chk("hold",  REG_HOLD,   32'(m_act));
    chk("busy",  BUSY,       32'(m_act | m_fin));
    chk("done",  DONE,       32'(m_fin));
  end

  task automatic cyc();
    @(negedge CLK);
    #1;
  endtask

  // One readout: optional stall of stall_len cycles once stall_after bits are accepted,
  // optional START/FFFF poke in cycle poke_at. Returns collected word and DONE cycle.
  task automatic readout(input logic [W-1:0] w, input int stall_after, input int stall_len,
                         input int poke_at, output logic [W-1:0] got, output int done_at);
    int nb = 0, st = 0;
    got = '0; done_at = -1;
    DATA_IN = w; START = 1;
    cyc();
    START = 0; DATA_IN = W'($urandom);
    for (int n = 1; n < 100 && done_at < 0; n++) begin
      SOUT_READY = !(nb == stall_after && st < stall_len);
      if (SOUT_VALID && !SOUT_READY) begin
        st++;
        chk("stall_bit", SOUT, 32'(w[W-1-nb]));
      end
      if (SOUT_VALID && SOUT_READY) begin got = {got[W-2:0], SOUT}; nb++; end
      if (DONE) done_at = n;
      if (n == poke_at) begin START = 1; DATA_IN = 16'hFFFF; end
      else START = 0;
      cyc();
    end
    SOUT_READY = 1; START = 0;
  endtask

  initial begin
    logic [W-1:0] got, g1, g2;
    int d, d2, nb2, cnt;
    logic first;
    #1 R_N = 0;
    #1 chk("rst_outputs", {SOUT, SOUT_VALID, REG_HOLD, BUSY, DONE}, 0);
    cyc(); cyc();
    R_N = 1;
    cyc();
    readout(16'hA5C3, -1, 0, -1, got, d);
    chk("a5c3_stream", got, 16'hA5C3);
    chk("a5c3_done", d, 17);
    cyc();
    readout(16'hA5C3, 3, 3, -1, got, d);
    chk("stall_stream", got, 16'hA5C3);
    chk("stall_done", d, 20);
    cyc();
    readout(16'hA5C3, -1, 0, 5, got, d);
    chk("poke_stream", got, 16'hA5C3);
    chk("poke_done", d, 17);
    repeat (4) begin
      chk("no_extra", BUSY, 0);
      cyc();
    end
    DATA_IN = 16'hA5C3; START = 1;
    cyc();
    START = 0;
    repeat (6) cyc();
    chk("b7_valid", SOUT_VALID, 1);
    chk("b7_bit", SOUT, 0);
    #2 R_N = 0;
    #1 chk("rst_async", {SOUT, SOUT_VALID, REG_HOLD, BUSY, DONE}, 0);
    cnt = 0;
    repeat (3) begin cyc(); cnt += int'(DONE); end
    R_N = 1;
    repeat (3) begin cyc(); cnt += int'(DONE) + int'(BUSY); end
    chk("rst_no_done", cnt, 0);
    readout(16'hA5C3, -1, 0, -1, got, d);
    chk("after_rst_stream", got, 16'hA5C3);
    chk("after_rst_done", d, 17);
    cyc();
    START = 1; DATA_IN = 16'h0001;
    cyc();
    d = -1; d2 = -1; g1 = '0; g2 = '0; nb2 = 0; first = 0;
    for (int n = 1; n < 80 && d2 < 0; n++) begin
      if (n == 3) DATA_IN = 16'h8000;
      if (SOUT_VALID) begin
        if (d < 0) g1 = {g1[W-2:0], SOUT};
        else begin
          if (nb2 == 0) first = SOUT;
          g2 = {g2[W-2:0], SOUT};
          nb2++;
        end
      end
      if (DONE) begin
        if (d < 0) d = n;
        else begin d2 = n; START = 0; end
      end
      cyc();
    end
    START = 0;
    chk("b2b_first_word", g1, 16'h0001);
    chk("b2b_second_word", g2, 16'h8000);
    chk("b2b_first_done", d, 17);
    chk("b2b_spacing", d2 - d, 18);
    chk("b2b_second_msb", first, 1);
    cyc();
    repeat (3000) begin
      START = $urandom_range(0, 3) == 0;
      DATA_IN = W'($urandom);
      SOUT_READY = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 299) == 0) begin
        #2 R_N = 0;
        #1 chk("rand_rst", {SOUT, SOUT_VALID, REG_HOLD, BUSY, DONE}, 0);
        cyc();
        R_N = 1;
      end
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
